// File: rtl/rv32_fetch_pc.sv
// Barrel-hart fetch PC generator: one PC per hart, round-robin issue over enabled harts.
// Optional same-cycle redirect bypass onto fetch_pc: define RV32_FETCH_REDIRECT_BYPASS_EN.
module rv32_fetch_pc #(
  parameter int          NUM_HARTS = 8,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_HARTS-1:0]         hart_en,
  input  logic                         redirect_valid,
  input  logic [$clog2(NUM_HARTS)-1:0] redirect_hart,
  input  logic [31:0]                  redirect_pc,
  output logic                         fetch_valid,
  input  logic                         fetch_ready,
  output logic [31:0]                  fetch_pc,
  output logic [$clog2(NUM_HARTS)-1:0] fetch_hart,
  output logic [1:0]                   cur_state
);

  localparam int HW = $clog2(NUM_HARTS);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_e;

  state_e        state_q;
  logic [HW-1:0] ptr_q;
  logic [31:0]   pc_q [NUM_HARTS];
  logic [31:0]   pc_d [NUM_HARTS];

  logic [31:0]   redirect_aligned;
  logic          handshake;
  logic          any_en;
  logic [HW-1:0] nxt_ptr;
  logic [HW-1:0] cand;
  logic          nxt_found;

  // Handshake contract: a request is accepted at a rising edge where fetch_valid
  // and fetch_ready are both high; fetch_pc may change while valid waits on ready.
  assign redirect_aligned = redirect_pc & 32'hFFFF_FFFC;
  assign any_en           = |hart_en;
  assign fetch_valid      = (state_q == RUN) && hart_en[ptr_q];
  assign handshake        = fetch_valid && fetch_ready;
  assign fetch_hart       = ptr_q;
  assign cur_state        = state_q;

  always_comb begin
    fetch_pc = pc_q[ptr_q];
`ifdef RV32_FETCH_REDIRECT_BYPASS_EN
    if (rst_n && redirect_valid && (redirect_hart == ptr_q)) begin
      fetch_pc = redirect_aligned;
    end
`endif
  end

  // First enabled hart strictly after ptr in circular order; stay put if none.
  always_comb begin
    nxt_ptr   = ptr_q;
    nxt_found = 1'b0;
    cand      = '0;
    for (int i = 1; i < NUM_HARTS; i++) begin
      cand = ptr_q + HW'(i);
      if (!nxt_found && hart_en[cand]) begin
        nxt_ptr   = cand;
        nxt_found = 1'b1;
      end
    end
  end

  // With bypass, a redirect to the issuing hart is already folded into fetch_pc,
  // so the +4 of that fetch must be kept instead of being overwritten.
  always_comb begin
    for (int h = 0; h < NUM_HARTS; h++) begin
      pc_d[h] = pc_q[h];
      if (handshake && (ptr_q == HW'(h))) begin
        pc_d[h] = fetch_pc + 32'd4;
      end
      if (redirect_valid && (redirect_hart == HW'(h))) begin
`ifdef RV32_FETCH_REDIRECT_BYPASS_EN
        if (!(handshake && (ptr_q == HW'(h)))) begin
          pc_d[h] = redirect_aligned;
        end
`else
        pc_d[h] = redirect_aligned;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
      ptr_q   <= '0;
      for (int h = 0; h < NUM_HARTS; h++) begin
        pc_q[h] <= RESET_PC;
      end
    end else begin
      for (int h = 0; h < NUM_HARTS; h++) begin
        pc_q[h] <= pc_d[h];
      end
      case (state_q)
        BOOT: state_q <= any_en ? RUN : HALT;
        RUN: begin
          if (!any_en) begin
            state_q <= HALT;
          end
          if (handshake || !hart_en[ptr_q]) begin
            ptr_q <= nxt_ptr;
          end
        end
        HALT: begin
          if (any_en) begin
            state_q <= RUN;
          end
        end
        default: state_q <= BOOT;
      endcase
    end
  end

endmodule
